asg_series_checker: RTL and testbench
=====================================

# asg_series_checker

Downstream consumer of the arithmetic sequence generator. It takes the generator's `term`/`valid`/`done` stream and the same `a1`/`d`/`n` configuration. It accumulates a signed running sum and counts terms. It checks every term against the expected value `a1 + k*d` and the final count against `n`. When the sequence ends, it presents the sum and pass/fail flags on a valid/ready result port.

## Interface
- `DATA_W`, default 32: term and configuration width; terms are signed two's complement.
- `SUM_W`, default 64: accumulator width; must be greater than `DATA_W`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; captures configuration and arms the block.
- `a1` in DATA_W: first term, sampled on `start`.
- `d` in DATA_W: common difference, sampled on `start`.
- `n` in DATA_W: expected term count, unsigned, sampled on `start`.
- `term_in` in DATA_W: term from generator.
- `term_valid` in 1: `term_in` is valid this cycle.
- `seq_done` in 1: generator done; level-sensitive.
- `busy` out 1: block is in ACCUM.
- `partial_sum` out SUM_W: running signed sum of accepted terms.
- `term_count` out DATA_W: number of terms accepted so far.
- `result_valid` out 1: result fields are valid.
- `result_ready` in 1: result consumer accepts the result.
- `result_sum` out SUM_W: final signed sum.
- `result_count` out DATA_W: final term count.
- `term_err` out 1: at least one term differed from its expected value.
- `count_err` out 1: final count differs from `n`.
- `mismatch_idx` out DATA_W: zero-based index of the first mismatching term; 0 if none.

## Operation
- States are IDLE, ACCUM and REPORT.
- On `start` in any state: capture `a1`, `d`, `n`; set `exp_term` = `a1`; clear the sum, count and error flags; drop `result_valid`; go to ACCUM. `start` has priority over every other input that cycle.
- **IDLE:** `term_valid` and `seq_done` are ignored.
- **ACCUM, on each `term_valid`:**
  - Add the sign-extended `term_in` to the sum.
  - Increment the count, saturating at all-ones.
  - Compare `term_in` with `exp_term`. On the first mismatch, set `term_err` and latch the current count (before increment) into `mismatch_idx`.
  - Update `exp_term` += `d`, modulo 2^DATA_W. This matches generator wrap-around.
- **ACCUM to REPORT:** when `seq_done` is high, go to REPORT.
  - A `term_valid` in the same cycle as `seq_done` is accumulated first.
  - Load the result registers from the updated sum and count.
  - Set `count_err` = (final count != `n`).
- **REPORT:** hold `result_valid` and all result fields stable. When `result_valid && result_ready`, go to IDLE. Terms arriving in REPORT are ignored and do not alter the result.
- Terms beyond `n` that arrive before `seq_done` are still accumulated and checked. The resulting count exceeds `n`, which yields `count_err`.
- `n` = 0 with `seq_done` arriving with no terms gives sum 0, count 0, no errors.
- `seq_done` staying high after the handshake has no effect until the next `start`.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- `start` at cycle t: `busy` = 1 from t+1. A `term_valid` at t is not accumulated.
- A term with `term_valid` at cycle t is reflected in `partial_sum` and `term_count` at t+1.
- `seq_done` first sampled high at cycle t in ACCUM: `result_valid` = 1 and `busy` = 0 at t+1.
- Handshake at cycle t: `result_valid` = 0 at t+1. There is no combinational path from `result_ready` to any output.
- Back-to-back operation: `start` in the handshake cycle wins; the result is consumed and the block goes to ACCUM.
- Reset asserted mid-ACCUM or mid-REPORT: all outputs go to 0 immediately. The block stays idle until the next `start`.

## Test plan
- a1 = 1, d = 2, n = 4, terms 1, 3, 5, 7, then `seq_done`: `result_sum` = 16, `result_count` = 4, `term_err` = 0, `count_err` = 0.
- a1 = 10, d = -3, n = 5, terms 10, 7, 4, 1, -2: `result_sum` = 20 (signed), no errors. `partial_sum` steps 10, 17, 21, 22, 20 on successive cycles.
- a1 = 1, d = 2, n = 4, terms 1, 3, 6, 7: `term_err` = 1, `mismatch_idx` = 2, `result_sum` = 17, `count_err` = 0.
- a1 = 1, d = 2, n = 4, only 3 terms, then `seq_done`: `count_err` = 1, `result_count` = 3, `result_sum` = 9.
- a1 = 0x7FFFFFFF, d = 1, n = 2, terms 0x7FFFFFFF then 0x80000000: no `term_err`, `result_sum` = -1.
- Case 1 with `result_ready` held low for 5 cycles after `result_valid` rises: fields stay stable and `result_valid` stays high; `result_valid` falls one cycle after `result_ready` rises. Repeat with `rst_n` pulsed low after the second term: all outputs return to 0, and a later `start` runs a clean sequence.

Source files
------------

// File: rtl/asg_series_checker_if.sv
// asg_series_checker_if: generator stream, configuration and result port of the series checker
interface asg_series_checker_if #(
    parameter int DATA_W = 32,
    parameter int SUM_W  = 64
);
    logic              start;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] term_in;
    logic              term_valid;
    logic              seq_done;
    logic              busy;
    logic [SUM_W-1:0]  partial_sum;
    logic [DATA_W-1:0] term_count;
    logic              result_valid;
    logic              result_ready;
    logic [SUM_W-1:0]  result_sum;
    logic [DATA_W-1:0] result_count;
    logic              term_err;
    logic              count_err;
    logic [DATA_W-1:0] mismatch_idx;

    modport slave (
        input  start, a1, d, n, term_in, term_valid, seq_done, result_ready,
        output busy, partial_sum, term_count, result_valid, result_sum,
               result_count, term_err, count_err, mismatch_idx
    );

    modport master (
        output start, a1, d, n, term_in, term_valid, seq_done, result_ready,
        input  busy, partial_sum, term_count, result_valid, result_sum,
               result_count, term_err, count_err, mismatch_idx
    );
endinterface

// File: rtl/asg_series_checker.sv
// asg_series_checker: sums and checks an arithmetic-sequence term stream against a1 + k*d,
// then reports sum, count and error flags on a valid/ready result port.
module asg_series_checker #(
    parameter int DATA_W = 32,
    parameter int SUM_W  = 64
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    asg_series_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t            r_state, w_state;
    logic [DATA_W-1:0] r_exp, r_d, r_n, r_count, r_result_count, r_mismatch_idx;
    logic [SUM_W-1:0]  r_sum, r_result_sum;
    logic              r_busy, r_result_valid, r_term_err, r_count_err;

    logic [SUM_W-1:0]  w_ext, w_sum_acc;
    logic [DATA_W-1:0] w_cnt_acc;
    logic              w_take, w_miss, w_fin, w_ack;

    assign w_ext     = {{(SUM_W-DATA_W){bus.term_in[DATA_W-1]}}, bus.term_in};
    assign w_take    = (r_state == ACCUM) && bus.term_valid;
    assign w_sum_acc = w_take ? r_sum + w_ext : r_sum;
    assign w_cnt_acc = (w_take && !(&r_count)) ? r_count + 1'b1 : r_count;
    // only the first mismatch is latched; later ones leave the index alone
    assign w_miss    = w_take && (bus.term_in != r_exp) && !r_term_err;
    assign w_fin     = (r_state == ACCUM) && bus.seq_done;
    assign w_ack     = (r_state == REPORT) && r_result_valid && bus.result_ready;

    always_comb begin
        w_state = r_state;
        if (bus.start)
            w_state = ACCUM;
        else if (w_fin)
            w_state = REPORT;
        else if (w_ack)
            w_state = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_exp          <= '0;
            r_d            <= '0;
            r_n            <= '0;
            r_sum          <= '0;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_sum   <= '0;
            r_result_count <= '0;
            r_term_err     <= 1'b0;
            r_count_err    <= 1'b0;
            r_mismatch_idx <= '0;
        end else begin
            r_state <= w_state;
            r_busy  <= (w_state == ACCUM);
            if (bus.start) begin
                r_exp          <= bus.a1;
                r_d            <= bus.d;
                r_n            <= bus.n;
                r_sum          <= '0;
                r_count        <= '0;
                r_result_valid <= 1'b0;
                r_term_err     <= 1'b0;
                r_count_err    <= 1'b0;
                r_mismatch_idx <= '0;
            end else begin
                r_sum   <= w_sum_acc;
                r_count <= w_cnt_acc;
                r_exp   <= w_take ? r_exp + r_d : r_exp;
                if (w_miss) begin
                    r_term_err     <= 1'b1;
                    r_mismatch_idx <= r_count;
                end
                // a term arriving with seq_done is already folded into w_sum_acc/w_cnt_acc
                if (w_fin) begin
                    r_result_sum   <= w_sum_acc;
                    r_result_count <= w_cnt_acc;
                    r_count_err    <= (w_cnt_acc != r_n);
                    r_result_valid <= 1'b1;
                end else if (w_ack) begin
                    r_result_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.partial_sum  = r_sum;
    assign bus.term_count   = r_count;
    assign bus.result_valid = r_result_valid;
    assign bus.result_sum   = r_result_sum;
    assign bus.result_count = r_result_count;
    assign bus.term_err     = r_term_err;
    assign bus.count_err    = r_count_err;
    assign bus.mismatch_idx = r_mismatch_idx;
endmodule

// File: tb/tb_asg_series_checker.sv
// tb_asg_series_checker: directed vectors with hand-computed sums, counts and error flags
module tb_asg_series_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    asg_series_checker_if #(.DATA_W(32), .SUM_W(64)) bus();

    asg_series_checker #(.DATA_W(32), .SUM_W(64)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_psum"}, bus.partial_sum, 64'd0);
        check({tag, "_cnt"}, 64'(bus.term_count), 64'd0);
        check({tag, "_rv"}, 64'(bus.result_valid), 64'd0);
        check({tag, "_rsum"}, bus.result_sum, 64'd0);
        check({tag, "_rcnt"}, 64'(bus.result_count), 64'd0);
        check({tag, "_terr"}, 64'(bus.term_err), 64'd0);
        check({tag, "_cerr"}, 64'(bus.count_err), 64'd0);
        check({tag, "_idx"}, 64'(bus.mismatch_idx), 64'd0);
    endtask

    task automatic check_result(input string tag, input logic [63:0] sum, input logic [31:0] cnt,
                                input logic terr, input logic cerr, input logic [31:0] idx);
        check({tag, "_rv"}, 64'(bus.result_valid), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_rsum"}, bus.result_sum, sum);
        check({tag, "_rcnt"}, 64'(bus.result_count), 64'(cnt));
        check({tag, "_terr"}, 64'(bus.term_err), 64'(terr));
        check({tag, "_cerr"}, 64'(bus.count_err), 64'(cerr));
        check({tag, "_idx"}, 64'(bus.mismatch_idx), 64'(idx));
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] dd, input logic [31:0] nn);
        bus.start = 1'b1;
        bus.a1    = a;
        bus.d     = dd;
        bus.n     = nn;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [31:0] t, input logic done);
        bus.term_valid = 1'b1;
        bus.term_in    = t;
        bus.seq_done   = done;
        @(negedge clk);
        bus.term_valid = 1'b0;
        bus.seq_done   = 1'b0;
    endtask

    task automatic end_seq();
        bus.seq_done = 1'b1;
        @(negedge clk);
        bus.seq_done = 1'b0;
    endtask

    task automatic ack(input string tag);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check({tag, "_ack_rv"}, 64'(bus.result_valid), 64'd0);
    endtask

    task automatic run_case1();
        do_start(32'd1, 32'd2, 32'd4);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b0);
        end_seq();
    endtask

    int t2[5] = '{10, 7, 4, 1, -2};
    int p2[5] = '{10, 17, 21, 22, 20};

    initial begin
        bus.start = 0; bus.a1 = 0; bus.d = 0; bus.n = 0; bus.term_in = 0;
        bus.term_valid = 0; bus.seq_done = 0; bus.result_ready = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // case 1: plain sequence
        do_start(32'd1, 32'd2, 32'd4);
        check("c1_busy", 64'(bus.busy), 64'd1);
        check("c1_psum0", bus.partial_sum, 64'd0);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b0);
        check("c1_cnt", 64'(bus.term_count), 64'd4);
        end_seq();
        check_result("c1", 64'd16, 32'd4, 1'b0, 1'b0, 32'd0);
        ack("c1");

        // case 2: negative difference, partial sum per cycle
        do_start(32'd10, 32'hFFFF_FFFD, 32'd5);
        for (int i = 0; i < 5; i++) begin
            send(32'(t2[i]), 1'b0);
            check("c2_psum", bus.partial_sum, 64'(p2[i]));
        end
        end_seq();
        check_result("c2", 64'd20, 32'd5, 1'b0, 1'b0, 32'd0);
        ack("c2");

        // case 3: mismatch at index 2, last term arrives with seq_done
        do_start(32'd1, 32'd2, 32'd4);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        send(32'd6, 1'b0);
        send(32'd7, 1'b1);
        check_result("c3", 64'd17, 32'd4, 1'b1, 1'b0, 32'd2);
        send(32'd100, 1'b0);
        check("c3_report_rsum", bus.result_sum, 64'd17);
        check("c3_report_psum", bus.partial_sum, 64'd17);
        ack("c3");

        // case 4: short sequence
        do_start(32'd1, 32'd2, 32'd4);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        end_seq();
        check_result("c4", 64'd9, 32'd3, 1'b0, 1'b1, 32'd0);
        ack("c4");

        // case 5: expected-term wrap-around
        do_start(32'h7FFF_FFFF, 32'd1, 32'd2);
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h8000_0000, 1'b0);
        end_seq();
        check_result("c5", 64'hFFFF_FFFF_FFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0);
        ack("c5");

        // n = 0, term on the start cycle must not count, seq_done held through handshake
        bus.term_valid = 1'b1;
        bus.term_in    = 32'd5;
        do_start(32'd3, 32'd1, 32'd0);
        bus.term_valid = 1'b0;
        check("n0_psum", bus.partial_sum, 64'd0);
        bus.seq_done = 1'b1;
        @(negedge clk);
        check_result("n0", 64'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        ack("n0");
        repeat (3) @(negedge clk);
        check("n0_hold_rv", 64'(bus.result_valid), 64'd0);
        check("n0_hold_busy", 64'(bus.busy), 64'd0);
        bus.seq_done = 1'b0;

        // extra terms with a mismatch, then start in the handshake cycle
        do_start(32'd1, 32'd2, 32'd2);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        send(32'd9, 1'b0);
        end_seq();
        check_result("xt", 64'd13, 32'd3, 1'b1, 1'b1, 32'd2);
        bus.result_ready = 1'b1;
        do_start(32'd1, 32'd2, 32'd4);
        bus.result_ready = 1'b0;
        check("b2b_rv", 64'(bus.result_valid), 64'd0);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        check("b2b_psum", bus.partial_sum, 64'd0);
        check("b2b_terr", 64'(bus.term_err), 64'd0);
        check("b2b_cerr", 64'(bus.count_err), 64'd0);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b0);
        end_seq();
        check_result("b2b", 64'd16, 32'd4, 1'b0, 1'b0, 32'd0);
        ack("b2b");

        // case 6: result held while ready is low
        run_case1();
        for (int i = 0; i < 5; i++) begin
            check_result("hold", 64'd16, 32'd4, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
        end
        ack("hold");

        // reset in the middle of ACCUM
        do_start(32'd1, 32'd2, 32'd4);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        check("mr_psum", bus.partial_sum, 64'd4);
        rst_n = 1'b0;
        #1;
        check_zero("mr");
        @(negedge clk);
        rst_n = 1'b1;
        send(32'd5, 1'b0);
        check("mr_idle_psum", bus.partial_sum, 64'd0);
        check("mr_idle_busy", 64'(bus.busy), 64'd0);
        end_seq();
        check("mr_idle_rv", 64'(bus.result_valid), 64'd0);
        run_case1();
        check_result("mr_clean", 64'd16, 32'd4, 1'b0, 1'b0, 32'd0);
        ack("mr_clean");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
